// File: rtl/herring_bus_decoder.sv
// Herring bus decoder: registered chip selects, RAM write strobe and phi2 wait-state stretching.
// Optional RDY timeout is enabled by defining HERRING_RDY_TIMEOUT_EN.
module herring_bus_decoder #(
  parameter int NUM_CS = 5,
  parameter int ADDR_BITS = 6,
  parameter logic [NUM_CS*ADDR_BITS-1:0] CS_BASE =
    {6'b111000, 6'b100011, 6'b100010, 6'b100001, 6'b100000},
  parameter logic [NUM_CS*ADDR_BITS-1:0] CS_MASK =
    {6'b111000, 6'b111111, 6'b111111, 6'b111111, 6'b111111},
  parameter logic [NUM_CS*4-1:0] CS_WAIT = {4'd0, 4'd2, 4'd0, 4'd1, 4'd1},
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_src,
  input  logic                 reset,
  input  logic                 cpu_clk_out,
  input  logic                 rw,
  input  logic [ADDR_BITS-1:0] address,
  output logic [NUM_CS-1:0]    cs_n,
  output logic                 ram_we_n,
  output logic                 rdy,
  output logic                 timeout_flag
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: rdy=0 holds the CPU in the current cycle; released on the W-th phi2 fall.
  state_t                 state;
  logic                   phi2_m;
  logic                   phi2_s;
  logic                   phi2_d;
  logic [ADDR_BITS-1:0]   addr_r;
  logic                   rw_r;
  logic [3:0]             count;
  logic [NUM_CS-1:0]      cs_next;
  logic [3:0]             win_wait;
  logic                   rise;
  logic                   fall;

  assign rise = phi2_s & ~phi2_d;
  assign fall = ~phi2_s & phi2_d;

  // Descending scan so the lowest-index hit is the last assignment and wins.
  always_comb begin
    cs_next  = '1;
    win_wait = '0;
    for (int k = NUM_CS - 1; k >= 0; k--) begin
      if ((addr_r & CS_MASK[k*ADDR_BITS +: ADDR_BITS]) ==
          (CS_BASE[k*ADDR_BITS +: ADDR_BITS] & CS_MASK[k*ADDR_BITS +: ADDR_BITS])) begin
        cs_next  = ~(NUM_CS'(1) << k);
        win_wait = CS_WAIT[k*4 +: 4];
      end
    end
  end

`ifdef HERRING_RDY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] to_cnt;
  logic          to_flag;
  assign timeout_flag = to_flag;
`else
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clk_src) begin
    if (reset) begin
      phi2_m   <= 1'b0;
      phi2_s   <= 1'b0;
      phi2_d   <= 1'b0;
      addr_r   <= '0;
      rw_r     <= 1'b1;
      cs_n     <= '1;
      ram_we_n <= 1'b1;
      rdy      <= 1'b1;
      count    <= '0;
      state    <= S_IDLE;
`ifdef HERRING_RDY_TIMEOUT_EN
      to_cnt   <= '0;
      to_flag  <= 1'b0;
`endif
    end else begin
      phi2_m   <= cpu_clk_out;
      phi2_s   <= phi2_m;
      phi2_d   <= phi2_s;
      addr_r   <= address;
      rw_r     <= rw;
      cs_n     <= cs_next;
      ram_we_n <= ~(phi2_s & ~rw_r);

      case (state)
        S_IDLE: begin
          if (rise && (win_wait != 4'd0)) begin
            count <= win_wait;
            rdy   <= 1'b0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (fall) begin
            if (count == 4'd1) begin
              rdy   <= 1'b1;
              count <= 4'd0;
              state <= S_DONE;
            end else begin
              count <= count - 4'd1;
            end
          end
        end
        S_DONE: begin
          // Completing edge of the stretched cycle; its rise is ignored.
          if (fall) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

`ifdef HERRING_RDY_TIMEOUT_EN
      if (!rdy) begin
        if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          rdy     <= 1'b1;
          state   <= S_IDLE;
          count   <= 4'd0;
          to_flag <= 1'b1;
          to_cnt  <= '0;
        end else begin
          to_cnt <= to_cnt + TW'(1);
        end
      end else begin
        to_cnt <= '0;
      end
`endif
    end
  end

endmodule
